// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Purpose  : Shares one single-port memory bus between instruction fetch and
//            load/store. Optional round-robin arbitration: MEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [XLEN-1:0] i_rdata,
   output logic            i_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_wstrb,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [8:0] C_TIMEOUT = 9'(TIMEOUT);

   state_t          state_q, state_d;
   logic            owner_q, owner_d;  // 1 = data port owns the transaction
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q, we_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
   logic            d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [XLEN-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

   logic            grant_to_data;
   logic            timeout_hit;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid, rsp_err;
   logic [XLEN-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
   logic rr_q, rr_d;  // 1 = data port wins the next contention
   assign grant_to_data = d_req && (!i_req || rr_q);
`else
   assign grant_to_data = d_req;
`endif

   // Counter holds BUSY cycles already spent; this cycle is the last allowed one.
   assign timeout_hit = (C_TIMEOUT != 9'd0) && (({1'b0, cnt_q} + 9'd1) == C_TIMEOUT);
   assign req_addr    = grant_to_data ? d_addr : i_addr;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      wstrb_d   = wstrb_q;
      cnt_d     = cnt_q;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
`ifdef MEM_ARB_RR_EN
      rr_d      = rr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (d_req || i_req) begin
               d_gnt   = grant_to_data;
               i_gnt   = !grant_to_data;
               owner_d = grant_to_data;
               addr_d  = req_addr;
               we_d    = grant_to_data & d_we;
               wdata_d = grant_to_data ? d_wdata : '0;
               wstrb_d = grant_to_data ? d_wstrb : 4'h0;
               cnt_d   = 8'd0;
`ifdef MEM_ARB_RR_EN
               rr_d    = !grant_to_data;
`endif
               // Misaligned requests never reach memory; the error is answered directly.
               if (req_addr[1:0] != 2'b00) begin
                  state_d   = ST_FAULT;
                  rsp_valid = 1'b1;
                  rsp_err   = 1'b1;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               rsp_valid = 1'b1;
               rsp_data  = we_q ? '0 : mem_rdata;
            end else if (timeout_hit) begin
               state_d   = ST_IDLE;
               rsp_valid = 1'b1;
               rsp_err   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_FAULT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      i_rvalid_d = rsp_valid & ~owner_d;
      i_err_d    = rsp_err & ~owner_d;
      i_rdata_d  = owner_d ? '0 : rsp_data;
      d_rvalid_d = rsp_valid & owner_d;
      d_err_d    = rsp_err & owner_d;
      d_rdata_d  = owner_d ? rsp_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         wstrb_q    <= 4'h0;
         cnt_q      <= 8'd0;
         i_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         i_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         wstrb_q    <= wstrb_d;
         cnt_q      <= cnt_d;
         i_rvalid_q <= i_rvalid_d;
         i_err_q    <= i_err_d;
         i_rdata_q  <= i_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b1;
      else     rr_q <= rr_d;
   end
`endif

   assign mem_req   = (state_q == ST_BUSY);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   assign i_rvalid  = i_rvalid_q;
   assign i_err     = i_err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_arbiter
// Purpose  : Directed self-checking bench for riscv_mem_arbiter (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid, i_err;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int compared = 0;
   int mismatched = 0;

   riscv_mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      logic [143:0] obs;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      obs = {i_gnt, i_rvalid, i_err, i_rdata, d_gnt, d_rvalid, d_err, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, 4'h0};
      compared++;
      if (obs !== 144'h0) begin
         mismatched++;
         $display("FAIL reset_outputs got %h want 0", obs);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      @(negedge clk); i_req = 1'b1; i_addr = 32'h100; #1;
      compared++;
      if ({i_gnt, d_gnt, mem_req} !== 3'b100) begin
         mismatched++; $display("FAIL fetch_gnt got %b want 100", {i_gnt, d_gnt, mem_req});
      end
      @(negedge clk); i_req = 1'b0; i_addr = '0; mem_ack = 1'b1; mem_rdata = 32'h13; #1;
      compared++;
      if ({mem_req, mem_we, i_gnt, mem_addr} !== {3'b100, 32'h100}) begin
         mismatched++; $display("FAIL fetch_mem got %h want %h", {mem_req, mem_we, i_gnt, mem_addr}, {3'b100, 32'h100});
      end
      @(negedge clk); mem_ack = 1'b0; mem_rdata = '0; #1;
      compared++;
      if ({i_rvalid, i_err, i_rdata, d_rvalid, mem_req} !== {2'b10, 32'h13, 2'b00}) begin
         mismatched++; $display("FAIL fetch_rsp got %h want %h", {i_rvalid, i_err, i_rdata, d_rvalid, mem_req}, {2'b10, 32'h13, 2'b00});
      end
      @(negedge clk); #1;
      compared++;
      if (i_rvalid !== 1'b0) begin
         mismatched++; $display("FAIL fetch_pulse got %b want 0", i_rvalid);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; #1;
      compared++;
      if ({d_gnt, i_gnt} !== 2'b10) begin
         mismatched++; $display("FAIL store_gnt got %b want 10", {d_gnt, i_gnt});
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         d_req = 1'b0; d_we = 1'b0; d_addr = 32'h5; d_wdata = 32'h12345678; d_wstrb = 4'h0;
         mem_ack = (k == 3); mem_rdata = 32'hFFFFFFFF; #1;
         compared++;
         if ({mem_req, mem_we, d_rvalid, mem_wstrb, mem_addr, mem_wdata} !== {3'b110, 4'hF, 32'h2000, 32'hDEADBEEF}) begin
            mismatched++; $display("FAIL store_hold cycle %0d got %h want %h", k,
               {mem_req, mem_we, d_rvalid, mem_wstrb, mem_addr, mem_wdata}, {3'b110, 4'hF, 32'h2000, 32'hDEADBEEF});
         end
      end
      @(negedge clk); mem_ack = 1'b0; mem_rdata = '0; #1;
      compared++;
      if ({d_rvalid, d_err, d_rdata, i_rvalid, mem_req} !== {2'b10, 32'h0, 2'b00}) begin
         mismatched++; $display("FAIL store_rsp got %h want %h", {d_rvalid, d_err, d_rdata, i_rvalid, mem_req}, {2'b10, 32'h0, 2'b00});
      end
   endtask

   task automatic test_contention();
      int d_left = 2;
      int i_left = 2;
      int n = 0;
      logic [3:0] seq = '0;  // bit k = 1 when grant k went to the data port
      logic [3:0] want;
`ifdef MEM_ARB_RR_EN
      want = 4'b0101;
`else
      want = 4'b0011;
`endif
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         @(negedge clk);
         d_req = (d_left > 0); i_req = (i_left > 0);
         d_we = 1'b0; d_addr = 32'h400; i_addr = 32'h500;
         mem_ack = mem_req; mem_rdata = 32'(cyc); #1;
         compared++;
         if (d_gnt && i_gnt) begin
            mismatched++; $display("FAIL contention_one_gnt got d=%b i=%b want one", d_gnt, i_gnt);
         end
         if (d_gnt) begin seq[n] = 1'b1; n++; d_left--; end
         else if (i_gnt) begin seq[n] = 1'b0; n++; i_left--; end
      end
      compared++;
      if (n !== 4) begin
         mismatched++; $display("FAIL contention_count got %0d want 4", n);
      end
      compared++;
      if (seq !== want) begin
         mismatched++; $display("FAIL contention_order got %b want %b", seq, want);
      end
      @(negedge clk); d_req = 1'b0; i_req = 1'b0; mem_ack = mem_req;
      @(negedge clk); mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1002; #1;
      compared++;
      if ({d_gnt, i_gnt} !== 2'b10) begin
         mismatched++; $display("FAIL mis_gnt got %b want 10", {d_gnt, i_gnt});
      end
      @(negedge clk); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h101; #1;
      compared++;
      if ({mem_req, d_rvalid, d_err, i_rvalid, i_gnt, d_rdata} !== {5'b01100, 32'h0}) begin
         mismatched++; $display("FAIL mis_rsp got %h want %h", {mem_req, d_rvalid, d_err, i_rvalid, i_gnt, d_rdata}, {5'b01100, 32'h0});
      end
      @(negedge clk); #1;
      compared++;
      if ({i_gnt, d_rvalid, mem_req} !== 3'b100) begin
         mismatched++; $display("FAIL mis_regrant got %b want 100", {i_gnt, d_rvalid, mem_req});
      end
      @(negedge clk); i_req = 1'b0; #1;
      compared++;
      if ({i_rvalid, i_err, mem_req, d_rvalid, i_rdata} !== {4'b1100, 32'h0}) begin
         mismatched++; $display("FAIL mis_fetch_rsp got %h want %h", {i_rvalid, i_err, mem_req, d_rvalid, i_rdata}, {4'b1100, 32'h0});
      end
      @(negedge clk); #1;
   endtask

   task automatic test_timeout();
      @(negedge clk); i_req = 1'b1; i_addr = 32'h200; mem_ack = 1'b0; #1;
      compared++;
      if (i_gnt !== 1'b1) begin
         mismatched++; $display("FAIL tmo_gnt got %b want 1", i_gnt);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); i_req = 1'b0; #1;
         compared++;
         if ({mem_req, i_rvalid} !== 2'b10) begin
            mismatched++; $display("FAIL tmo_wait cycle %0d got %b want 10", k, {mem_req, i_rvalid});
         end
      end
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
      compared++;
      if ({mem_req, i_rvalid, i_err, i_rdata} !== {3'b011, 32'h0}) begin
         mismatched++; $display("FAIL tmo_rsp got %h want %h", {mem_req, i_rvalid, i_err, i_rdata}, {3'b011, 32'h0});
      end
      @(negedge clk); mem_ack = 1'b0; mem_rdata = '0; #1;
      compared++;
      if ({i_rvalid, d_rvalid, mem_req, i_gnt, d_gnt} !== 5'b0) begin
         mismatched++; $display("FAIL tmo_late_ack got %b want 00000", {i_rvalid, d_rvalid, mem_req, i_gnt, d_gnt});
      end
   endtask

   task automatic test_collision();
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; #1;
      compared++;
      if (d_gnt !== 1'b1) begin
         mismatched++; $display("FAIL coll_gnt got %b want 1", d_gnt);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); d_req = 1'b0; mem_ack = (k == 4); mem_rdata = 32'hCAFEF00D; #1;
         compared++;
         if ({mem_req, d_rvalid} !== 2'b10) begin
            mismatched++; $display("FAIL coll_wait cycle %0d got %b want 10", k, {mem_req, d_rvalid});
         end
      end
      @(negedge clk); mem_ack = 1'b0; mem_rdata = '0; #1;
      compared++;
      if ({d_rvalid, d_err, i_rvalid, d_rdata} !== {3'b100, 32'hCAFEF00D}) begin
         mismatched++; $display("FAIL coll_rsp got %h want %h", {d_rvalid, d_err, i_rvalid, d_rdata}, {3'b100, 32'hCAFEF00D});
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); i_req = 1'b1; i_addr = 32'h600;
      @(negedge clk); i_req = 1'b0; #1;
      compared++;
      if (mem_req !== 1'b1) begin
         mismatched++; $display("FAIL rstmid_busy got %b want 1", mem_req);
      end
      #2 rst = 1'b1; #1;
      compared++;
      if (mem_req !== 1'b0) begin
         mismatched++; $display("FAIL rstmid_async got %b want 0", mem_req);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         compared++;
         if ({i_rvalid, d_rvalid, mem_req} !== 3'b000) begin
            mismatched++; $display("FAIL rstmid_quiet cycle %0d got %b want 000", k, {i_rvalid, d_rvalid, mem_req});
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); i_req = 1'b1; i_addr = 32'h700;
      @(negedge clk); i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
      mem_ack = 1'b1; mem_rdata = 32'h11; #1;
      compared++;
      if (d_gnt !== 1'b0) begin
         mismatched++; $display("FAIL b2b_busy_gnt got %b want 0", d_gnt);
      end
      @(negedge clk); mem_ack = 1'b0; #1;
      compared++;
      if ({i_rvalid, d_gnt, i_rdata} !== {2'b11, 32'h11}) begin
         mismatched++; $display("FAIL b2b_overlap got %h want %h", {i_rvalid, d_gnt, i_rdata}, {2'b11, 32'h11});
      end
      @(negedge clk); d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22; #1;
      compared++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h800}) begin
         mismatched++; $display("FAIL b2b_mem got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h800});
      end
      @(negedge clk); mem_ack = 1'b0; #1;
      compared++;
      if ({d_rvalid, d_err, i_rvalid, d_rdata} !== {3'b100, 32'h22}) begin
         mismatched++; $display("FAIL b2b_rsp got %h want %h", {d_rvalid, d_err, i_rvalid, d_rdata}, {3'b100, 32'h22});
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_misaligned();
      test_timeout();
      test_collision();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
